// File: rtl/ssio_ddr_out_fmt_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ssio_ddr_out_fmt_if                                          |
// | Description : Frame-word stream into the DDR output formatter.             |
// |               s_data  - frame word, low half rising edge, high half falling|
// |               s_last  - final word of frame                                |
// |               s_err   - word carries a transmit error                      |
// |               s_valid - word valid                                         |
// |               s_ready - formatter can accept a word                        |
// |               master: word source, slave: formatter.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ssio_ddr_out_fmt_if #(
  parameter int WIDTH = 4
);
  logic [2*WIDTH-1:0] s_data;
  logic               s_last;
  logic               s_err;
  logic               s_valid;
  logic               s_ready;

  modport master (output s_data, output s_last, output s_err, output s_valid, input s_ready);
  modport slave  (input s_data, input s_last, input s_err, input s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/ssio_ddr_out_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ssio_ddr_out_fmt                                             |
// | Description : Transmit formatter for a source-synchronous DDR link.        |
// |               Buffers SDR frame words and emits rising/falling-edge data,  |
// |               control and forwarded-clock pairs for pin-level oddr cells.  |
// |               Handles frame start threshold, inter-frame gap and underflow.|
// | Ports       : clk, rst_n (async assert, active low)                        |
// |               s_if          - slave side of ssio_ddr_out_fmt_if            |
// |               data_q1/q2    - rising/falling-edge data                     |
// |               ctl_q1/q2     - rising/falling-edge control                  |
// |               clk_q1/q2     - forwarded-clock pattern                      |
// |               underflow     - one-cycle pulse when a frame starves         |
// |               frame_cnt     - completed frames (wraps)                     |
// |               underflow_cnt - underflow events (wraps)                     |
// | Config      : SSIO_DDR_OUT_FMT_STATS_EN - defined: live frame/underflow    |
// |               counters; undefined: counter ports tied to zero.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ssio_ddr_out_fmt #(
  parameter int WIDTH       = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int START_LEVEL = 4,
  parameter int IFG_CYCLES  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  ssio_ddr_out_fmt_if.slave  s_if,
  output logic [WIDTH-1:0]   data_q1,
  output logic [WIDTH-1:0]   data_q2,
  output logic               ctl_q1,
  output logic               ctl_q2,
  output logic               clk_q1,
  output logic               clk_q2,
  output logic               underflow,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        underflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2*WIDTH + 2;
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] START_LVL = LW'(START_LEVEL);
  localparam logic [GW-1:0] GAP_LAST  = GW'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Buffer storage: {err, last, data}
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  // Number of buffered words carrying last; lets IDLE start short frames.
  logic [LW-1:0]    last_cnt_q, last_cnt_d;
  logic             ready_q, ready_d;

  state_t           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic [WIDTH-1:0] d1_q, d1_d, d2_q, d2_d;
  logic             c1_q, c1_d, c2_q, c2_d;
  logic             uf_q, uf_d;
  logic             clk1_q;

  logic             push, pop;
  logic             frame_inc, uf_inc;
  logic [EW-1:0]    rd_ent;
  logic             rd_last, rd_err;
  logic             fifo_empty, start_ok;

  assign push       = s_if.s_valid & ready_q;
  assign rd_ent     = mem_q[rd_ptr_q];
  assign rd_last    = rd_ent[2*WIDTH];
  assign rd_err     = rd_ent[2*WIDTH+1];
  assign fifo_empty = (level_q == '0);
  assign start_ok   = (level_q >= START_LVL) || (last_cnt_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_if.s_err, s_if.s_last, s_if.s_data};
    end
  end

  // Level and last-count bookkeeping; push+pop together cancel out.
  always_comb begin
    level_d    = level_q;
    last_cnt_d = last_cnt_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    case ({push & s_if.s_last, pop & rd_last})
      2'b10:   last_cnt_d = last_cnt_q + LW'(1);
      2'b01:   last_cnt_d = last_cnt_q - LW'(1);
      default: last_cnt_d = last_cnt_q;
    endcase
    ready_d = (level_d != FULL_LVL);
  end

  // Frame sequencing; output values computed here are registered below.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    pop       = 1'b0;
    d1_d      = '0;
    d2_d      = '0;
    c1_d      = 1'b0;
    c2_d      = 1'b0;
    uf_d      = 1'b0;
    frame_inc = 1'b0;
    uf_inc    = 1'b0;
    case (state_q)
      ST_IDLE, ST_SEND: begin
        if ((state_q == ST_IDLE) ? start_ok : !fifo_empty) begin
          pop  = 1'b1;
          d1_d = rd_ent[WIDTH-1:0];
          d2_d = rd_ent[2*WIDTH-1:WIDTH];
          c1_d = 1'b1;
          c2_d = ~rd_err;
          if (rd_last) begin
            state_d   = ST_GAP;
            gap_d     = '0;
            frame_inc = 1'b1;
          end else begin
            state_d = ST_SEND;
          end
        end else if (state_q == ST_SEND) begin
          // Starved mid-frame: one error cycle, then discard the rest.
          c1_d    = 1'b1;
          uf_d    = 1'b1;
          uf_inc  = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (rd_last) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      last_cnt_q <= '0;
      ready_q    <= 1'b0;
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      c1_q       <= 1'b0;
      c2_q       <= 1'b0;
      uf_q       <= 1'b0;
      clk1_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      last_cnt_q <= last_cnt_d;
      ready_q    <= ready_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      uf_q       <= uf_d;
      clk1_q     <= 1'b1;
    end
  end

`ifdef SSIO_DDR_OUT_FMT_STATS_EN
  logic [15:0] frame_cnt_q, underflow_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q     <= '0;
      underflow_cnt_q <= '0;
    end else begin
      if (frame_inc) frame_cnt_q     <= frame_cnt_q + 16'd1;
      if (uf_inc)    underflow_cnt_q <= underflow_cnt_q + 16'd1;
    end
  end

  assign frame_cnt     = frame_cnt_q;
  assign underflow_cnt = underflow_cnt_q;
`else
  logic unused_stats;
  assign unused_stats  = frame_inc | uf_inc;
  assign frame_cnt     = '0;
  assign underflow_cnt = '0;
`endif

  assign s_if.s_ready = ready_q;
  assign data_q1      = d1_q;
  assign data_q2      = d2_q;
  assign ctl_q1       = c1_q;
  assign ctl_q2       = c2_q;
  assign underflow    = uf_q;
  assign clk_q1       = clk1_q;
  // Falling half of the forwarded clock is always low.
  assign clk_q2       = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ssio_ddr_out_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ssio_ddr_out_fmt                                          |
// | Description : Self-checking bench for ssio_ddr_out_fmt. Two instances:     |
// |               dut0 with START_LEVEL=4, dut1 with START_LEVEL=8.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ssio_ddr_out_fmt;
  localparam int W     = 4;
  localparam int DEPTH = 8;
  localparam int IFG   = 2;
  localparam int SL0   = 4;
  localparam int SL1   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] in_data [2];
  logic       in_last [2];
  logic       in_err  [2];
  logic       in_valid[2];

  int n_tests = 0;
  int n_fail  = 0;

  ssio_ddr_out_fmt_if #(.WIDTH(W)) ifa ();
  ssio_ddr_out_fmt_if #(.WIDTH(W)) ifb ();

  assign ifa.s_data  = in_data[0];
  assign ifa.s_last  = in_last[0];
  assign ifa.s_err   = in_err[0];
  assign ifa.s_valid = in_valid[0];
  assign ifb.s_data  = in_data[1];
  assign ifb.s_last  = in_last[1];
  assign ifb.s_err   = in_err[1];
  assign ifb.s_valid = in_valid[1];

  logic [3:0]  a_d1, a_d2, b_d1, b_d2;
  logic        a_c1, a_c2, a_k1, a_k2, a_uf, b_c1, b_c2, b_k1, b_k2, b_uf;
  logic [15:0] a_fc, a_uc, b_fc, b_uc;

  ssio_ddr_out_fmt #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .START_LEVEL(SL0), .IFG_CYCLES(IFG)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_if(ifa),
    .data_q1(a_d1), .data_q2(a_d2), .ctl_q1(a_c1), .ctl_q2(a_c2),
    .clk_q1(a_k1), .clk_q2(a_k2), .underflow(a_uf),
    .frame_cnt(a_fc), .underflow_cnt(a_uc));

  ssio_ddr_out_fmt #(.WIDTH(W), .FIFO_DEPTH(DEPTH), .START_LEVEL(SL1), .IFG_CYCLES(IFG)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_if(ifb),
    .data_q1(b_d1), .data_q2(b_d2), .ctl_q1(b_c1), .ctl_q2(b_c2),
    .clk_q1(b_k1), .clk_q2(b_k2), .underflow(b_uf),
    .frame_cnt(b_fc), .underflow_cnt(b_uc));

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int v);
`ifdef SSIO_DDR_OUT_FMT_STATS_EN
    return v & 16'hFFFF;
`else
    return (v & 0);
`endif
  endfunction

  // ---------------- behavioural model ----------------
  // Phases: 0 waiting for start, 1 sending, 2 discarding, 3 gap.
  int         m_st[2], m_gap[2], m_cnt[2], m_head[2];
  int         m_mem[2][DEPTH];
  logic [3:0] e_d1[2], e_d2[2];
  bit         e_c1[2], e_c2[2], e_k1[2], e_uf[2], e_rdy[2];
  int         e_fc[2], e_uc[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_gap[i] = 0; m_cnt[i] = 0; m_head[i] = 0;
      e_d1[i] = 0; e_d2[i] = 0; e_c1[i] = 0; e_c2[i] = 0;
      e_k1[i] = 0; e_uf[i] = 0; e_rdy[i] = 0; e_fc[i] = 0; e_uc[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int lvl, sl, w;
    bit anyl, take, show;
    sl   = (i == 0) ? SL0 : SL1;
    lvl  = m_cnt[i];
    anyl = 0;
    for (int k = 0; k < lvl; k++) begin
      w = m_mem[i][(m_head[i] + k) % DEPTH];
      if (w[8]) anyl = 1;
    end
    w = m_mem[i][m_head[i]];
    take = 0; show = 0;
    e_d1[i] = 0; e_d2[i] = 0; e_c1[i] = 0; e_c2[i] = 0; e_uf[i] = 0;
    case (m_st[i])
      0: if (lvl >= sl || anyl) begin take = 1; show = 1; end
      1: begin
        if (lvl > 0) begin
          take = 1; show = 1;
        end else begin
          e_c1[i] = 1; e_uf[i] = 1; e_uc[i]++; m_st[i] = 2;
        end
      end
      2: if (lvl > 0) take = 1;
      default: begin
        m_gap[i]++;
        if (m_gap[i] == IFG) m_st[i] = 0;
      end
    endcase
    if (take) begin
      m_head[i] = (m_head[i] + 1) % DEPTH;
      m_cnt[i]--;
      if (show) begin
        e_d1[i] = w[3:0]; e_d2[i] = w[7:4]; e_c1[i] = 1; e_c2[i] = !w[9]; m_st[i] = 1;
      end
      if (w[8]) begin
        if (show) e_fc[i]++;
        m_st[i] = 3; m_gap[i] = 0;
      end
    end
    if (in_valid[i] && e_rdy[i]) begin
      m_mem[i][(m_head[i] + m_cnt[i]) % DEPTH] = {22'd0, in_err[i], in_last[i], in_data[i]};
      m_cnt[i]++;
    end
    e_rdy[i] = (m_cnt[i] != DEPTH);
    e_k1[i]  = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_inst(input int i, input logic [3:0] d1, input logic [3:0] d2,
                          input logic c1, input logic c2, input logic k1, input logic k2,
                          input logic u, input logic r, input logic [15:0] f, input logic [15:0] uc);
    chk($sformatf("dut%0d.data_q1", i), int'(d1), int'(e_d1[i]));
    chk($sformatf("dut%0d.data_q2", i), int'(d2), int'(e_d2[i]));
    chk($sformatf("dut%0d.ctl_q1", i), int'(c1), int'(e_c1[i]));
    chk($sformatf("dut%0d.ctl_q2", i), int'(c2), int'(e_c2[i]));
    chk($sformatf("dut%0d.clk_q1", i), int'(k1), int'(e_k1[i]));
    chk($sformatf("dut%0d.clk_q2", i), int'(k2), 0);
    chk($sformatf("dut%0d.underflow", i), int'(u), int'(e_uf[i]));
    chk($sformatf("dut%0d.s_ready", i), int'(r), int'(e_rdy[i]));
    chk($sformatf("dut%0d.frame_cnt", i), int'(f), exp_cnt(e_fc[i]));
    chk($sformatf("dut%0d.underflow_cnt", i), int'(uc), exp_cnt(e_uc[i]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, a_d1, a_d2, a_c1, a_c2, a_k1, a_k2, a_uf, ifa.s_ready, a_fc, a_uc);
    cmp_inst(1, b_d1, b_d2, b_c1, b_c2, b_k1, b_k2, b_uf, ifb.s_ready, b_fc, b_uc);
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  function automatic logic rdy_of(input int i);
    return (i == 0) ? ifa.s_ready : ifb.s_ready;
  endfunction

  function automatic logic c1_of(input int i);
    return (i == 0) ? a_c1 : b_c1;
  endfunction

  task automatic push(input int i, input logic [7:0] d, input logic l, input logic e);
    int b;
    in_valid[i] = 1'b1; in_data[i] = d; in_last[i] = l; in_err[i] = e;
    b = 0;
    while (!rdy_of(i) && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (b >= 50) chk("push_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic idle(input int i);
    in_valid[i] = 1'b0; in_last[i] = 1'b0; in_err[i] = 1'b0; in_data[i] = '0;
  endtask

  task automatic wait_ctl(input int i);
    int b;
    b = 0;
    while (!c1_of(i) && b < 40) begin
      @(negedge clk);
      b++;
    end
    if (b >= 40) chk("wait_ctl_timeout", 0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b;
    for (int i = 0; i < 2; i++) idle(i);
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.clk_q1", int'(a_k1), 0);
    chk("reset.s_ready", int'(ifa.s_ready), 0);
    chk("reset.ctl_q1", int'(a_c1), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.clk_q1", int'(a_k1), 1);
    chk("idle.clk_q2", int'(a_k2), 0);
    chk("idle.s_ready", int'(ifa.s_ready), 1);
    chk("idle.data_q1", int'(a_d1), 0);

    // 3-word frame
    push(0, 8'h21, 1'b0, 1'b0);
    push(0, 8'h43, 1'b0, 1'b0);
    push(0, 8'h65, 1'b1, 1'b0);
    idle(0);
    wait_ctl(0);
    chk("f1.w0.q1", int'(a_d1), 1); chk("f1.w0.q2", int'(a_d2), 2); chk("f1.w0.ctl", int'({a_c1, a_c2}), 3);
    @(negedge clk);
    chk("f1.w1.q1", int'(a_d1), 3); chk("f1.w1.q2", int'(a_d2), 4); chk("f1.w1.ctl", int'({a_c1, a_c2}), 3);
    @(negedge clk);
    chk("f1.w2.q1", int'(a_d1), 5); chk("f1.w2.q2", int'(a_d2), 6); chk("f1.w2.ctl", int'({a_c1, a_c2}), 3);
    @(negedge clk);
    chk("f1.gap0.ctl", int'({a_c1, a_c2}), 0);
    @(negedge clk);
    chk("f1.gap1.ctl", int'({a_c1, a_c2}), 0);
    chk("f1.frame_cnt", int'(a_fc), exp_cnt(1));

    // error word in position 2
    repeat (3) @(negedge clk);
    push(0, 8'h21, 1'b0, 1'b0);
    push(0, 8'h43, 1'b0, 1'b1);
    push(0, 8'h65, 1'b1, 1'b0);
    idle(0);
    wait_ctl(0);
    chk("err.w0.ctl", int'({a_c1, a_c2}), 3);
    @(negedge clk);
    chk("err.w1.ctl", int'({a_c1, a_c2}), 2);
    @(negedge clk);
    chk("err.w2.ctl", int'({a_c1, a_c2}), 3);

    // underflow after 4 non-last words
    repeat (4) @(negedge clk);
    push(0, 8'h10, 1'b0, 1'b0);
    push(0, 8'h32, 1'b0, 1'b0);
    push(0, 8'h54, 1'b0, 1'b0);
    push(0, 8'h76, 1'b0, 1'b0);
    idle(0);
    b = 0;
    while (!a_uf && b < 40) begin @(negedge clk); b++; end
    if (b >= 40) chk("uf_timeout", 0, 1);
    chk("uf.ctl", int'({a_c1, a_c2}), 2);
    chk("uf.data", int'({a_d2, a_d1}), 0);
    chk("uf.underflow_cnt", int'(a_uc), exp_cnt(1));
    @(negedge clk);
    chk("uf.pulse_end", int'(a_uf), 0);
    push(0, 8'h98, 1'b0, 1'b0);
    push(0, 8'hBA, 1'b1, 1'b0);
    idle(0);
    repeat (6) @(negedge clk);
    chk("uf.frame_cnt", int'(a_fc), exp_cnt(2));

    // full buffer on dut1 (START_LEVEL = 8)
    for (int k = 0; k < 8; k++) push(1, 8'(k * 17 + 1), 1'b0, 1'b0);
    chk("full.s_ready_lo", int'(ifb.s_ready), 0);
    in_data[1] = 8'hE7; in_last[1] = 1'b0;
    @(negedge clk);
    chk("full.s_ready_reopen", int'(ifb.s_ready), 1);
    @(negedge clk);
    push(1, 8'hC3, 1'b0, 1'b0);
    push(1, 8'hA5, 1'b0, 1'b0);
    push(1, 8'h5A, 1'b1, 1'b0);
    idle(1);
    repeat (20) @(negedge clk);
    chk("full.frame_cnt", int'(b_fc), exp_cnt(1));

    // asynchronous reset during the second word
    push(0, 8'h1F, 1'b0, 1'b0);
    push(0, 8'h2E, 1'b0, 1'b0);
    push(0, 8'h3D, 1'b0, 1'b0);
    push(0, 8'h4C, 1'b0, 1'b0);
    idle(0);
    wait_ctl(0);
    @(posedge clk);
    #2;
    chk("mrst.pre.q1", int'(a_d1), 4'hE);
    rst_n = 1'b0;
    #1;
    chk("mrst.data", int'({a_d2, a_d1}), 0);
    chk("mrst.ctl", int'({a_c1, a_c2}), 0);
    chk("mrst.clk_q1", int'(a_k1), 0);
    chk("mrst.s_ready", int'(ifa.s_ready), 0);
    chk("mrst.frame_cnt", int'(a_fc), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(0, 8'h21, 1'b0, 1'b0);
    push(0, 8'h43, 1'b0, 1'b0);
    push(0, 8'h65, 1'b1, 1'b0);
    idle(0);
    wait_ctl(0);
    chk("post.w0.q1", int'(a_d1), 1);
    chk("post.w0.q2", int'(a_d2), 2);
    repeat (4) @(negedge clk);
    chk("post.frame_cnt", int'(a_fc), exp_cnt(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ssio_ddr_out_fmt.md
# ssio_ddr_out_fmt

Transmit-side formatter for a source-synchronous DDR link. It buffers SDR frame words from the MAC-side logic and emits per-cycle rising/falling-edge data pairs and control pairs. It also emits a forwarded-clock pattern, suitable for direct connection to `oddr` instances at the pins. It is the transmit counterpart of the DDR input capture path and handles frame start threshold, inter-frame gap, and underflow signalling.

## Interface
- `WIDTH`, 4, data bits per DDR edge.
- `FIFO_DEPTH`, 8, word buffer depth. Power of 2, ≥4.
- `START_LEVEL`, 4, FIFO level (1..FIFO_DEPTH) that starts a frame when no `last` word is buffered.
- `IFG_CYCLES`, 2, idle cycles forced after each frame (≥1).
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `s_data`  in  2*WIDTH  frame word; `[WIDTH-1:0]` goes on the rising edge, `[2*WIDTH-1:WIDTH]` on the falling edge.
- `s_last`  in  1  final word of frame.
- `s_err`  in  1  word carries a transmit error.
- `s_valid`  in  1  word valid.
- `s_ready`  out  1  word accepted when `s_valid & s_ready`.
- `data_q1` / `data_q2`  out  WIDTH each  rising/falling-edge data to the data `oddr`.
- `ctl_q1` / `ctl_q2`  out  1 each  rising/falling-edge control to the control `oddr`.
- `clk_q1` / `clk_q2`  out  1 each  forwarded-clock pattern to the clock `oddr`.
- `underflow`  out  1  one-cycle pulse when a frame starves.
- `frame_cnt`  out  16  completed frames, wraps.
- `underflow_cnt`  out  16  underflow events, wraps.

## Operation
- FIFO stores `{s_err, s_last, s_data}`. Level is registered.
- `s_ready = (level != FIFO_DEPTH)`.
- A push and a pop in the same cycle leave the level unchanged.
- State machine `IDLE`, `SEND`, `DRAIN`, `GAP`:
  - `IDLE`: pop when `level >= START_LEVEL` or any buffered entry has `last`, then go to `SEND`. Otherwise drive idle.
  - `SEND`: pop one word per cycle.
    - Popped word drives `data_q1 = d[WIDTH-1:0]`, `data_q2 = d[2W-1:W]`, `ctl_q1 = 1`, `ctl_q2 = ~err`.
    - Popping a `last` word goes to `GAP` and increments `frame_cnt`.
  - `SEND` with the FIFO empty:
    - Drive `data = 0`, `ctl_q1 = 1`, `ctl_q2 = 0` (error pattern) for one cycle.
    - Pulse `underflow` and increment `underflow_cnt`.
    - Go to `DRAIN`.
  - `DRAIN`: pop and discard words with idle outputs until a `last` word is popped, then go to `GAP`. No `frame_cnt` increment.
  - `GAP`: idle outputs for exactly `IFG_CYCLES` cycles, then go to `IDLE`.
- Idle outputs: `data_q1/q2 = 0`, `ctl_q1/q2 = 0`.
- Forwarded clock out of reset: `clk_q1 = 1`, `clk_q2 = 0` every cycle.
- Counters saturate never; they wrap from 0xFFFF to 0.

## Timing
- Reset values of all outputs are 0, including `clk_q1`, `s_ready`, `underflow` and both counters. FIFO is empty and state is `IDLE`.
- `clk_q1` and `s_ready` go to 1 on the first clock edge after `rst_n` deasserts.
- All outputs are registered.
- A word accepted in cycle N raises the level in N+1. With `START_LEVEL=1`, that word is popped in N+1 and appears on `data_q*` in N+2.
- Back-to-back words in `SEND` are emitted in consecutive cycles with no bubble.
- Underflow is detected in the cycle the pop is due. The error pattern and `underflow` appear on the next clock edge.
- Asserting `rst_n` mid-frame clears outputs immediately (asynchronously) and discards FIFO contents.

## Configuration
- `SSIO_DDR_OUT_FMT_STATS_EN`
  - Defined: `frame_cnt` and `underflow_cnt` are live registers.
  - Not defined: both ports are tied to 0 and the counter logic is omitted; `underflow` is still generated.

## Test plan
- Reset/idle: release `rst_n`, no input. Expect `clk_q1 = 1`, `clk_q2 = 0`, `ctl = 00`, `data = 0`, `s_ready = 1` from cycle 1.
- 3-word frame, `START_LEVEL = 4`, words 0x21/0x43/0x65 with `last` on 0x65:
  - Expect `data_q1` = 1, 3, 5 and `data_q2` = 2, 4, 6 on consecutive cycles with `ctl = 11`.
  - Then `IFG_CYCLES` idle cycles, then `frame_cnt = 1`.
- Error word: `s_err = 1` on the 2nd word. Expect `ctl = 10` on that cycle only.
- Underflow: hold `s_valid` low after 4 non-last words.
  - Expect the error pattern for one cycle, a single `underflow` pulse, `underflow_cnt = 1`.
  - Later words up to `last` are discarded with `ctl = 00`, and `frame_cnt` stays unchanged.
- Full FIFO: push 8 words with no `last` and `START_LEVEL = 8` while stalled. Expect `s_ready = 0` at level 8, then a 1-cycle reopen once popping begins. No word is lost or duplicated (scoreboard).
- Mid-frame reset: assert `rst_n` low during the 2nd word. Expect all outputs 0 without waiting for a clock edge. After release, the next frame transmits cleanly.
